// File: rtl/reset_sequencer.sv
// Staged reset release for the video and CPU subsystems, driven by the PLL-lock reset.
// Also handles a soft CPU-only reset request that leaves the video domain untouched.
module reset_sequencer #(
  parameter int STABLE_CYCLES = 16,
  parameter int VIDEO_HOLD    = 64,
  parameter int CPU_HOLD      = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  output logic       video_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [1:0] state
);

  localparam int MAX_SV  = (STABLE_CYCLES > VIDEO_HOLD) ? STABLE_CYCLES : VIDEO_HOLD;
  localparam int MAX_CNT = (MAX_SV > CPU_HOLD) ? MAX_SV : CPU_HOLD;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] VIDEO_LAST  = CNT_W'(VIDEO_HOLD - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_HOLD - 1);

  typedef enum logic [1:0] {
    S_WAIT_STABLE = 2'd0,
    S_VIDEO_HOLD  = 2'd1,
    S_CPU_HOLD    = 2'd2,
    S_RUN         = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             video_reset_q, video_reset_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    video_reset_d = video_reset_q;
    cpu_reset_d   = cpu_reset_q;
    ready_d       = ready_q;

    unique case (state_q)
      S_WAIT_STABLE: begin
        video_reset_d = 1'b1;
        cpu_reset_d   = 1'b1;
        ready_d       = 1'b0;
        if (cnt_q == STABLE_LAST) begin
          state_d = S_VIDEO_HOLD;
          cnt_d   = '0;
        end
      end
      S_VIDEO_HOLD: begin
        video_reset_d = 1'b1;
        cpu_reset_d   = 1'b1;
        ready_d       = 1'b0;
        if (cnt_q == VIDEO_LAST) begin
          state_d       = S_CPU_HOLD;
          cnt_d         = '0;
          video_reset_d = 1'b0;
        end
      end
      S_CPU_HOLD: begin
        cpu_reset_d = 1'b1;
        ready_d     = 1'b0;
        // A repeated soft request restarts the hold so it is measured from the latest one.
        if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == CPU_LAST) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          cpu_reset_d = 1'b0;
          ready_d     = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d         = '0;
        video_reset_d = 1'b0;
        cpu_reset_d   = 1'b0;
        ready_d       = 1'b1;
        if (soft_rst_req) begin
          state_d     = S_CPU_HOLD;
          cpu_reset_d = 1'b1;
          ready_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_WAIT_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_STABLE;
      cnt_q         <= '0;
      video_reset_q <= 1'b1;
      cpu_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      video_reset_q <= video_reset_d;
      cpu_reset_q   <= cpu_reset_d;
      ready_q       <= ready_d;
    end
  end

  assign video_reset = video_reset_q;
  assign cpu_reset   = cpu_reset_q;
  assign ready       = ready_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed stimulus queues expected outputs tagged
// with the clock edge they belong to; a negedge monitor pops and compares them.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       video_reset;
  logic       cpu_reset;
  logic       ready;
  logic [1:0] state;

  reset_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .soft_rst_req (soft_rst_req),
    .video_reset  (video_reset),
    .cpu_reset    (cpu_reset),
    .ready        (ready),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Packed as {video_reset, cpu_reset, ready, state}
  localparam logic [4:0] E_RST = 5'b11000;
  localparam logic [4:0] E_VH  = 5'b11001;
  localparam logic [4:0] E_CH  = 5'b01010;
  localparam logic [4:0] E_RUN = 5'b00111;

  typedef struct {
    int         edge_n;
    logic [4:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   ecnt   = 0;
  int   base   = 0;
  int   total  = 0;
  int   passed = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int rel, input logic [4:0] v, input string nm);
    exp_t e;
    e.edge_n = base + rel;
    e.exp    = v;
    e.nm     = nm;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation whose edge has been reached.
  always @(negedge clk) begin
    logic [4:0] act;
    exp_t       e;
    act = {video_reset, cpu_reset, ready, state};
    while (q.size() > 0 && q[0].edge_n <= ecnt) begin
      e = q.pop_front();
      total++;
      if (e.edge_n != ecnt)
        $display("FAIL %s: missed edge %0d (now %0d)", e.nm, e.edge_n, ecnt);
      else if (act !== e.exp)
        $display("FAIL %s @edge %0d: got vid/cpu/rdy/st=%b required %b", e.nm, ecnt, act, e.exp);
      else
        passed++;
    end
  end

  initial begin
    // Power-up: reset held 10 cycles, then released
    step(10);
    base = ecnt;
    chk(0,   E_RST, "rst_values");
    chk(15,  E_RST, "stable_last");
    chk(16,  E_VH,  "enter_vhold");
    chk(79,  E_VH,  "vhold_last");
    chk(80,  E_CH,  "video_release");
    chk(335, E_CH,  "chold_last");
    chk(336, E_RUN, "cpu_release");
    reset = 1'b0;
    step(336);
    step(4);

    // Soft request from RUN
    base = ecnt + 1;
    chk(0,   E_CH,  "soft_enter");
    chk(255, E_CH,  "soft_hold_last");
    chk(256, E_RUN, "soft_release");
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(256);
    step(3);

    // Soft request repeated at hold cycle 100 restarts the hold
    base = ecnt + 1;
    chk(0,   E_CH,  "soft2_enter");
    chk(256, E_CH,  "restart_still_held");
    chk(355, E_CH,  "restart_hold_last");
    chk(356, E_RUN, "restart_release");
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(99);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(256);
    step(2);

    // Reset during CPU_HOLD, then a lock glitch in WAIT_STABLE, soft requests ignored
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(20);
    base = ecnt + 1;
    chk(0, E_RST, "rst_in_chold");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    base = ecnt;
    chk(0,   E_RST, "glitch_rst");
    chk(5,   E_RST, "glitch_restart");
    chk(15,  E_RST, "glitch_stable_last");
    chk(16,  E_VH,  "glitch_enter_vhold");
    chk(79,  E_VH,  "replay_vhold_last");
    chk(80,  E_CH,  "replay_video_release");
    chk(335, E_CH,  "replay_chold_last");
    chk(336, E_RUN, "replay_cpu_release");
    step(3);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(36);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(295);
    step(2);

    // Reset and soft request together in RUN: reset wins
    base = ecnt + 1;
    chk(0,   E_RST, "rst_over_soft");
    chk(80,  E_CH,  "final_video_release");
    chk(336, E_RUN, "final_cpu_release");
    reset = 1'b1;
    soft_rst_req = 1'b1;
    step(1);
    reset = 1'b0;
    soft_rst_req = 1'b0;
    step(336);
    @(negedge clk);
    #1;

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      $display("FAIL %s: never compared (edge %0d, now %0d)", e.nm, e.edge_n, ecnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
